// File: rtl/transmit_if.sv
// Load handshake between a byte producer and the serial transmitter.
// Ports: LOAD, OUT_PORT (producer -> tx), TX_RDY (tx -> producer).
interface transmit_if;
  logic       LOAD;
  logic [7:0] OUT_PORT;
  logic       TX_RDY;

  modport master (
    output LOAD,
    output OUT_PORT,
    input  TX_RDY
  );

  modport slave (
    input  LOAD,
    input  OUT_PORT,
    output TX_RDY
  );
endinterface

// File: rtl/transmit.sv
// Async serial transmitter: start, 7/8 data LSB first, opt parity, stop.
// Ports: clk, reset (sync low), k (bit time k+1), EIGHT/PEN/OHEL frame
// config, TX serial out, bus = LOAD/OUT_PORT/TX_RDY handshake.
// Define TX_BREAK_EN to add the BREAK input (hold line low while idle).
module transmit (
  input  logic        clk,
  input  logic        reset,
  input  logic [18:0] k,
  input  logic        EIGHT,
  input  logic        PEN,
  input  logic        OHEL,
`ifdef TX_BREAK_EN
  input  logic        BREAK,
`endif
  output logic        TX,
  transmit_if.slave   bus
);

  typedef enum logic {
    IDLE,
    SEND
  } state_t;

  state_t      state_q;
  state_t      state_d;

  logic        tx_q;
  logic        tx_d;
  logic        rdy_q;
  logic        rdy_d;

  logic [18:0] kq;
  logic [18:0] tcnt;
  logic [3:0]  bcnt;
  logic [3:0]  len_q;
  logic [9:0]  sh;

  logic        brk;
  logic        accept;
  logic        bit_end;
  logic        last;

  logic [7:0]  d;
  logic        par;
  logic [9:0]  rest;
  logic [3:0]  len_d;

`ifdef TX_BREAK_EN
  assign brk = BREAK;
`else
  assign brk = 1'b0;
`endif

  assign accept  = (state_q == IDLE)
                 && bus.LOAD && rdy_q && !brk;
  assign bit_end = (tcnt == kq);
  assign last    = bit_end && (bcnt == len_q);

  // Bits following the start bit; unused tail is
  // padded with 1 so the shifter idles high.
  assign d   = EIGHT ? bus.OUT_PORT
                     : {1'b0, bus.OUT_PORT[6:0]};
  assign par = (^d) ^ OHEL;

  always_comb begin
    rest = 10'h3ff;
    unique case (1'b1)
      (EIGHT && PEN):  rest = {1'b1, par, d};
      (EIGHT && !PEN): rest = {2'b11, d};
      (!EIGHT && PEN): rest = {2'b11, par, d[6:0]};
      default:         rest = {3'b111, d[6:0]};
    endcase
  end

  assign len_d = 4'd9
               + {3'b000, EIGHT}
               + {3'b000, PEN};

  always_ff @(posedge clk) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (accept) state_d = SEND;
      SEND: if (last)   state_d = IDLE;
      default:          state_d = IDLE;
    endcase
  end

  // Next values of the registered line and ready
  // flags; the start bit goes out right after the
  // accepting edge.
  always_comb begin
    tx_d  = tx_q;
    rdy_d = rdy_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          tx_d  = 1'b0;
          rdy_d = 1'b0;
        end else begin
          tx_d  = !brk;
          rdy_d = !brk;
        end
      end
      SEND: begin
        if (last) begin
          tx_d  = 1'b1;
          rdy_d = 1'b1;
        end else if (bit_end) begin
          tx_d  = sh[0];
        end
      end
      default: begin
        tx_d  = 1'b1;
        rdy_d = 1'b1;
      end
    endcase
  end

  // bcnt counts bits already placed on the line,
  // so it equals len_q during the stop bit.
  always_ff @(posedge clk) begin
    if (!reset) begin
      tx_q  <= 1'b1;
      rdy_q <= 1'b1;
      kq    <= '0;
      tcnt  <= '0;
      bcnt  <= '0;
      len_q <= '0;
      sh    <= '0;
    end else begin
      tx_q  <= tx_d;
      rdy_q <= rdy_d;
      if (accept) begin
        sh    <= rest;
        len_q <= len_d;
        kq    <= k;
        tcnt  <= '0;
        bcnt  <= 4'd1;
      end else if (state_q == SEND) begin
        if (bit_end) begin
          tcnt <= '0;
          if (!last) begin
            sh   <= {1'b1, sh[9:1]};
            bcnt <= bcnt + 4'd1;
          end
        end else begin
          tcnt <= tcnt + 19'd1;
        end
      end
    end
  end

  assign TX         = tx_q;
  assign bus.TX_RDY = rdy_q;

endmodule

// File: tb/tb_transmit.sv
// Directed bench for transmit: per-cycle {TX,TX_RDY} scoreboard
// fed by an independent frame model.
module tb_transmit;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [18:0] k = '0;
  logic        EIGHT = 1'b0;
  logic        PEN = 1'b0;
  logic        OHEL = 1'b0;
  logic        TX;
`ifdef TX_BREAK_EN
  logic        BREAK = 1'b0;
`endif

  transmit_if bus();

  transmit dut (
    .clk   (clk),
    .reset (reset),
    .k     (k),
    .EIGHT (EIGHT),
    .PEN   (PEN),
    .OHEL  (OHEL),
`ifdef TX_BREAK_EN
    .BREAK (BREAK),
`endif
    .TX    (TX),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [1:0] sbq[$];

  function automatic void push_frame(
    input logic [7:0]  dat,
    input logic [18:0] kk,
    input logic        e,
    input logic        p,
    input logic        o
  );
    logic bits[$];
    logic pb;
    int   nd;
    nd = e ? 8 : 7;
    pb = o;
    bits.push_back(1'b0);
    for (int i = 0; i < nd; i++) begin
      bits.push_back(dat[i]);
      pb = pb ^ dat[i];
    end
    if (p) bits.push_back(pb);
    bits.push_back(1'b1);
    foreach (bits[j])
      for (int c = 0; c <= int'(kk); c++)
        sbq.push_back({bits[j], 1'b0});
    sbq.push_back(2'b11);
  endfunction

  task automatic step_check(input string tag);
    logic [1:0] exp;
    @(posedge clk);
    #1;
    if (sbq.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s scoreboard empty got TX=%b want entry",
               tag, TX);
    end else begin
      exp = sbq.pop_front();
      checks++;
      assert (TX === exp[1]) else begin
        errors++;
        $error("FAIL %s TX got %b want %b", tag, TX, exp[1]);
      end
      checks++;
      assert (bus.TX_RDY === exp[0]) else begin
        errors++;
        $error("FAIL %s TX_RDY got %b want %b",
               tag, bus.TX_RDY, exp[0]);
      end
    end
  endtask

  task automatic idle(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      sbq.push_back(2'b11);
      step_check(tag);
    end
  endtask

  task automatic frame(
    input logic [7:0]  dat,
    input logic [18:0] kk,
    input logic        e,
    input logic        p,
    input logic        o,
    input int          busy_at,
    input int          rst_at,
    input string       tag
  );
    int n;
    k            = kk;
    EIGHT        = e;
    PEN          = p;
    OHEL         = o;
    bus.OUT_PORT = dat;
    bus.LOAD     = 1'b1;
    push_frame(dat, kk, e, p, o);
    n = sbq.size();
    for (int i = 0; i < n; i++) begin
      if (i == busy_at) begin
        bus.LOAD     = 1'b1;
        bus.OUT_PORT = 8'h00;
        EIGHT        = ~e;
        PEN          = ~p;
        OHEL         = ~o;
        k            = kk + 19'd5;
      end
      if (i == rst_at) begin
        reset = 1'b0;
        sbq.delete();
        sbq.push_back(2'b11);
        step_check({tag, "_rst"});
        reset    = 1'b1;
        bus.LOAD = 1'b0;
        return;
      end
      step_check(tag);
      bus.LOAD = 1'b0;
    end
  endtask

  initial begin
    bus.LOAD     = 1'b0;
    bus.OUT_PORT = 8'h00;
    sbq.push_back(2'b11);
    step_check("reset");
    bus.LOAD = 1'b1;
    sbq.push_back(2'b11);
    step_check("reset_load");
    reset    = 1'b1;
    bus.LOAD = 1'b0;
    idle(2, "post_reset");

    frame(8'hA5, 19'd3, 1'b1, 1'b1, 1'b0, -1, -1, "8E1_A5");
    idle(2, "gap1");
    frame(8'hFF, 19'd0, 1'b0, 1'b0, 1'b0, -1, -1, "7N1_FF");
    idle(1, "gap2");
    frame(8'h03, 19'd1, 1'b1, 1'b1, 1'b1, -1, -1, "8O1_03");
    idle(3, "gap3");
    frame(8'hC3, 19'd2, 1'b1, 1'b0, 1'b0, 10, -1, "busy");
    idle(2, "gap4");
    frame(8'h96, 19'd2, 1'b1, 1'b0, 1'b0, -1, 13, "rst_mid");
    idle(2, "gap5");
    frame(8'h3C, 19'd2, 1'b1, 1'b0, 1'b0, -1, -1, "after_rst");
    frame(8'h81, 19'd1, 1'b0, 1'b1, 1'b0, -1, -1, "b2b_a");
    frame(8'h7E, 19'd1, 1'b0, 1'b1, 1'b0, -1, -1, "b2b_b");
    frame(8'h5A, 19'd0, 1'b1, 1'b1, 1'b1, -1, -1, "b2b_c");
    idle(2, "tail");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
